shift_left_unit: RTL and testbench
==================================

Name: shift_left_unit

Overview:
- Registered logical left shifter for the datapath ALU.
- Shifts a 32-bit operand left by an amount supplied on a full-width operand bus and zero-fills from the LSB.
- The result, carry-out and valid flag are registered with one-cycle latency, so the block sits as a pipeline stage between the register-file operand buses and the ALU result mux.

Parameters:
- WIDTH, 32, data and shift-amount width in bits; must be a power of two ≥ 8.

Ports:
- clock  input  1  rising-edge clock
- clear  input  1  synchronous active-high reset
- in_valid  input  1  qualifies data_in/shift_amount this cycle
- data_in  input  WIDTH  operand to shift; bit pattern only, signedness ignored
- shift_amount  input  WIDTH  shift count, read as unsigned over the full WIDTH bits
- data_out  output  WIDTH  registered shifted result
- carry_out  output  1  registered last bit shifted out
- out_valid  output  1  registered copy of in_valid

Behaviour:
- Reset: on a rising clock with clear=1, data_out=0, carry_out=0, out_valid=0 (and overflow=0 when the optional feature is compiled in). Clear takes priority over in_valid. There is no asynchronous path.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on outputs after edge N. Full throughput: one new operation per cycle, no stall or back-pressure.
- Capture rule:
  - When in_valid=1, data_out, carry_out and out_valid load the new results.
  - When in_valid=0, out_valid loads 0 and data_out/carry_out hold their previous values.
- Shift rule, with amt = shift_amount as unsigned:
  - amt = 0: data_out = data_in, carry_out = 0.
  - 1 ≤ amt ≤ WIDTH−1: data_out = data_in << amt with zero fill; carry_out = data_in[WIDTH−amt].
  - amt = WIDTH: data_out = 0; carry_out = data_in[0].
  - amt > WIDTH, including any pattern with upper bits set (e.g., negative values): data_out = 0, carry_out = 0.
  - The amount is never truncated modulo WIDTH.
- Implementation: a log2(WIDTH)-stage combinational barrel shifter on amt[log2(WIDTH)−1:0], plus an "oversize" detect (any bit of amt at or above log2(WIDTH) set) that forces zero. Output registers follow the barrel shifter; there is no input register.
- Reset mid-operation: an operation captured on the same edge as clear is discarded and out_valid=0.

Optional Feature:
- Macro: SHIFT_LEFT_OVF_EN.
- Defined:
  - Adds output port overflow (1 bit, registered, same capture and reset rules as carry_out).
  - overflow=1 iff the signed value is not preserved by the shift:
    - for 1 ≤ amt ≤ WIDTH−1: bits data_in[WIDTH−1 : WIDTH−1−amt] are not all equal;
    - for amt ≥ WIDTH: data_in ≠ 0.
  - amt = 0 gives overflow=0.
- Undefined: the port is absent and no overflow logic is generated.
- All other behaviour is identical in both builds.

Decomposition:
- Package shift_pkg:
  - DATA_W=32
  - SHAMT_W = $clog2(DATA_W)
  - a typedef for the data word
- Sub-module shl_barrel: purely combinational log shifter. Inputs are data and the low SHAMT_W amount bits; outputs are the shifted data and the carry bit. shift_left_unit wraps it with oversize detection, optional overflow logic and the output registers.

Test Plan:
- Reset: hold clear=1 for 2 cycles with in_valid=1 and data_in=0xFFFFFFFF -> data_out=0, carry_out=0, out_valid=0.
- Basic: data_in=5, amt=3 -> after one edge data_out=40 (0x28), carry_out=0, out_valid=1. Next cycle data_in=6, amt=1 -> data_out=12.
- Edges:
  - data_in=0x12345678, amt=0 -> 0x12345678, carry=0.
  - data_in=1, amt=31 -> 0x80000000.
  - data_in=0x80000001, amt=1 -> 0x00000002, carry=1.
- Oversize: data_in=0xFFFFFFFF, amt=32 -> data_out=0, carry=1. Same data with amt=33 or amt=0xFFFFFFFF (−1) -> data_out=0, carry=0.
- Throughput/hold: back-to-back valid ops on consecutive cycles each appear one cycle later. Then in_valid=0 -> out_valid=0 and data_out holds the last result. Assert clear concurrently with a valid op -> outputs zeroed, op dropped.
- SHIFT_LEFT_OVF_EN build:
  - data_in=0x40000000, amt=1 -> overflow=1.
  - data_in=0xFFFFFFFE, amt=4 -> 0xFFFFFFE0, overflow=0.
  - data_in=0, amt=40 -> overflow=0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared widths and data word type for the left-shift datapath stage.
package shift_pkg;
  localparam int DATA_W  = 32;
  localparam int SHAMT_W = $clog2(DATA_W);

  typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/shl_barrel.sv
// Combinational log2(WIDTH)-stage left barrel shifter with carry of the last bit shifted out.
// Latency: 0 (pure combinational). Backpressure: none.
module shl_barrel
  import shift_pkg::*;
#(
  parameter int WIDTH   = DATA_W,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] amt,
  output logic [WIDTH-1:0]   shifted,
  output logic               carry
);

  // One extra bit above the word catches data[WIDTH-amt] as the last bit out.
  logic [WIDTH:0] ext;

  always_comb begin
    ext = {1'b0, data};
    for (int i = 0; i < SHAMT_W; i++) begin
      if (amt[i]) ext = ext << (1 << i);
    end
    shifted = ext[WIDTH-1:0];
    carry   = ext[WIDTH];
  end

endmodule

// File: rtl/shift_left_unit.sv
// Registered logical left shifter; oversize amounts zero the result. Optional overflow via SHIFT_LEFT_OVF_EN.
// Latency: 1 cycle, full throughput. Backpressure: none; outputs hold when in_valid=0.
module shift_left_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] shift_amount,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             out_valid
`ifdef SHIFT_LEFT_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]    amt_lo;
  logic             oversize;
  logic             amt_is_width;
  logic [WIDTH-1:0] barrel_dat;
  logic             barrel_carry;
  logic [WIDTH-1:0] res_dat;
  logic             res_carry;

  assign amt_lo       = shift_amount[SW-1:0];
  assign oversize     = |shift_amount[WIDTH-1:SW];
  assign amt_is_width = (shift_amount == WIDTH'(WIDTH));

  shl_barrel #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SW)
  ) u_barrel (
    .data    (data_in),
    .amt     (amt_lo),
    .shifted (barrel_dat),
    .carry   (barrel_carry)
  );

  // amt == WIDTH is oversize but still pushes data_in[0] out as the carry.
  assign res_dat   = oversize ? '0 : barrel_dat;
  assign res_carry = amt_is_width ? data_in[0] : (oversize ? 1'b0 : barrel_carry);

  always_ff @(posedge clock) begin
    if (clear) begin
      data_out  <= '0;
      carry_out <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out  <= res_dat;
        carry_out <= res_carry;
      end
    end
  end

`ifdef SHIFT_LEFT_OVF_EN
  logic res_ovf;

  // Signed value survives iff shifting back arithmetically restores the operand.
  always_comb begin
    if (oversize) res_ovf = |data_in;
    else          res_ovf = (WIDTH'($signed(barrel_dat) >>> amt_lo) != data_in);
  end

  always_ff @(posedge clock) begin
    if (clear)         overflow <= 1'b0;
    else if (in_valid) overflow <= res_ovf;
  end
`endif

endmodule

// File: tb/tb_shift_left_unit.sv
// Directed table-driven bench for shift_left_unit (both default and SHIFT_LEFT_OVF_EN builds).
module tb_shift_left_unit;
  import shift_pkg::*;

  typedef struct {
    logic  clr;
    logic  vld;
    word_t din;
    word_t amt;
    word_t exp_dat;
    logic  exp_carry;
    logic  exp_vld;
    logic  exp_ovf;
  } vec_t;

  logic  clock = 1'b0;
  logic  clear;
  logic  in_valid;
  word_t data_in;
  word_t shift_amount;
  word_t data_out;
  logic  carry_out;
  logic  out_valid;
`ifdef SHIFT_LEFT_OVF_EN
  logic  overflow;
`endif

  int checks = 0;
  int errors = 0;

  shift_left_unit #(.WIDTH(DATA_W)) dut (
    .clock        (clock),
    .clear        (clear),
    .in_valid     (in_valid),
    .data_in      (data_in),
    .shift_amount (shift_amount),
    .data_out     (data_out),
    .carry_out    (carry_out),
    .out_valid    (out_valid)
`ifdef SHIFT_LEFT_OVF_EN
    ,
    .overflow     (overflow)
`endif
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(logic c, logic v, word_t d, word_t a,
                              word_t ed, logic ec, logic ev, logic eo);
    vec_t r;
    r.clr = c; r.vld = v; r.din = d; r.amt = a;
    r.exp_dat = ed; r.exp_carry = ec; r.exp_vld = ev; r.exp_ovf = eo;
    return r;
  endfunction

  task automatic check_out(string name, word_t ed, logic ec, logic ev, logic eo);
    checks++;
    if (data_out !== ed) begin
      errors++;
      $display("FAIL %s data_out got %h want %h", name, data_out, ed);
    end
    checks++;
    if (carry_out !== ec) begin
      errors++;
      $display("FAIL %s carry_out got %b want %b", name, carry_out, ec);
    end
    checks++;
    if (out_valid !== ev) begin
      errors++;
      $display("FAIL %s out_valid got %b want %b", name, out_valid, ev);
    end
`ifdef SHIFT_LEFT_OVF_EN
    checks++;
    if (overflow !== eo) begin
      errors++;
      $display("FAIL %s overflow got %b want %b", name, overflow, eo);
    end
`else
    if (eo === 1'bx) $display("note: unexpected x in expected overflow for %s", name);
`endif
  endtask

  task automatic apply(logic c, logic v, word_t d, word_t a);
    clear = c; in_valid = v; data_in = d; shift_amount = a;
    @(posedge clock);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    // Each entry: inputs before an edge, expected registered outputs after it.
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 32'd0,  32'h0000_0000, 0, 0, 0)); // reset 1
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFF, 32'd0,  32'h0000_0000, 0, 0, 0)); // reset 2
    vecs.push_back(mk(0, 1, 32'd5,         32'd3,  32'h0000_0028, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'd6,         32'd1,  32'h0000_000C, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h1234_5678, 32'd0,  32'h1234_5678, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'd1,         32'd31, 32'h8000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'h8000_0001, 32'd1,  32'h0000_0002, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'd32, 32'h0000_0000, 1, 1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'd33, 32'h0000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'h1F00_0001, 32'd4,  32'hF000_0010, 1, 1, 1));
    vecs.push_back(mk(0, 0, 32'hDEAD_BEEF, 32'd5,  32'hF000_0010, 1, 0, 1)); // hold
    vecs.push_back(mk(0, 0, 32'h0000_0000, 32'd0,  32'hF000_0010, 1, 0, 1)); // hold
    vecs.push_back(mk(0, 1, 32'd3,         32'd2,  32'h0000_000C, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'd7,         32'd1,  32'h0000_0000, 0, 0, 0)); // clear drops op
    vecs.push_back(mk(0, 1, 32'h4000_0000, 32'd1,  32'h8000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFE, 32'd4,  32'hFFFF_FFE0, 1, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0000, 32'd40, 32'h0000_0000, 0, 1, 0));
    vecs.push_back(mk(0, 1, 32'h0000_0001, 32'h0000_0100, 32'h0000_0000, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0001, 32'd1,  32'h0000_0000, 0, 0, 1)); // hold

    clear = 1'b1; in_valid = 1'b0; data_in = '0; shift_amount = '0;

    foreach (vecs[i]) begin
      apply(vecs[i].clr, vecs[i].vld, vecs[i].din, vecs[i].amt);
      check_out($sformatf("vec%0d", i), vecs[i].exp_dat, vecs[i].exp_carry,
                vecs[i].exp_vld, vecs[i].exp_ovf);
    end

    // Back-to-back walk of a single one through every in-range amount.
    for (int k = 0; k < DATA_W; k++) begin
      word_t e;
      e = word_t'(1) << k;
      apply(0, 1, 32'd1, word_t'(k));
      check_out($sformatf("walk1_%0d", k), e, 1'b0, 1'b1, (k == DATA_W - 1));
    end

    // All-ones operand: every nonzero in-range amount shifts out a one.
    for (int k = 1; k < DATA_W; k += 5) begin
      word_t e;
      e = 32'hFFFF_FFFF << k;
      apply(0, 1, 32'hFFFF_FFFF, word_t'(k));
      check_out($sformatf("ones_%0d", k), e, 1'b1, 1'b1, 1'b0);
    end

    // Clear with idle input, then recovery on the next edge.
    apply(1, 0, 32'h0, 32'd0);
    check_out("clr_idle", 32'h0, 1'b0, 1'b0, 1'b0);
    apply(0, 1, 32'h0000_0003, 32'd30);
    check_out("recover", 32'hC000_0000, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
